wavetable_reader: RTL and testbench

Wavetable playback engine that drives the read side of the 512x16 single-port waveform RAM (the violin/strings table) and turns it into a stream of signed audio samples. On every sample-rate tick it advances a phase accumulator and reads the addressed entry; a compile-time option also reads the next entry and linearly interpolates between the two. It sits between the sample-rate timebase / note control and the mixer/DAC path. It never writes the RAM.

---
 rtl/synth_pkg.sv | 21 ++
 rtl/wt_lerp.sv | 23 ++
 rtl/wavetable_reader.sv | 131 +++++++++++++
 tb/tb_wavetable_reader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared wavetable constants, FSM state type and the offset-binary to signed conversion.
package synth_pkg;
   localparam int WT_ADDR_W = 9;
   localparam int WT_DATA_W = 16;
   localparam int PHASE_W   = 24;
   localparam int FRAC_W    = 8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD0,
      S_CAP0,
      S_RD1,
      S_CAP1,
      S_CALC
   } wt_state_t;

   // Offset-binary table entries become two's complement by flipping the MSB.
   function automatic logic signed [WT_DATA_W-1:0] wt_to_signed(input logic [WT_DATA_W-1:0] d);
      return {~d[WT_DATA_W-1], d[WT_DATA_W-2:0]};
   endfunction
endpackage

// File: rtl/wt_lerp.sv
// Combinational two-point interpolator: y = s0 + ((s1 - s0) * frac) >>> FRAC_W.
module wt_lerp
   import synth_pkg::*;
(
   input  logic signed [WT_DATA_W-1:0] i_s0,
   input  logic signed [WT_DATA_W-1:0] i_s1,
   input  logic        [FRAC_W-1:0]    i_frac,
   output logic signed [WT_DATA_W-1:0] o_y
);
   localparam int PROD_W = WT_DATA_W + 1 + FRAC_W + 1;

   logic signed [WT_DATA_W:0] w_diff;
   logic signed [PROD_W-1:0]  w_diff_x;
   logic signed [PROD_W-1:0]  w_frac_x;
   logic signed [PROD_W-1:0]  w_prod;

   assign w_diff   = {i_s1[WT_DATA_W-1], i_s1} - {i_s0[WT_DATA_W-1], i_s0};
   assign w_diff_x = {{(PROD_W-WT_DATA_W-1){w_diff[WT_DATA_W]}}, w_diff};
   assign w_frac_x = {{(PROD_W-FRAC_W){1'b0}}, i_frac};
   assign w_prod   = w_diff_x * w_frac_x;
   // The result lies between s0 and s1, so wrapping 16-bit addition is exact.
   assign o_y      = i_s0 + WT_DATA_W'(w_prod >>> FRAC_W);
endmodule

// File: rtl/wavetable_reader.sv
// Phase-accumulator wavetable player reading a 512x16 single-port RAM on each sample tick.
// Define WAVETABLE_INTERP_EN to add the second read and linear interpolation (latency 5, else 2).
module wavetable_reader
   import synth_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        sample_tick,
   input  logic        [PHASE_W-1:0]   phase_inc,
   output logic        [WT_ADDR_W-1:0] ram_addr,
   output logic                        ram_ce,
   output logic                        ram_re,
   output logic                        ram_we,
   output logic        [WT_DATA_W-1:0] ram_wdata,
   input  logic        [WT_DATA_W-1:0] ram_rdata,
   output logic signed [WT_DATA_W-1:0] sample_out,
   output logic                        sample_valid,
   output logic                        busy,
   output logic                        overrun
);
   wt_state_t                   r_state, w_next;
   logic [PHASE_W-1:0]          r_phase;
   logic [WT_ADDR_W-1:0]        r_addr;
   logic signed [WT_DATA_W-1:0] r_sample;
   logic                        r_valid;
   logic                        r_ovr;
   logic                        w_rd;

`ifdef WAVETABLE_INTERP_EN
   logic signed [WT_DATA_W-1:0] r_s0, r_s1, w_lerp;
   logic [FRAC_W-1:0]           r_frac;

   wt_lerp u_lerp (
      .i_s0   (r_s0),
      .i_s1   (r_s1),
      .i_frac (r_frac),
      .o_y    (w_lerp)
   );
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      w_rd   = 1'b0;
      case (r_state)
         S_IDLE: if (sample_tick) w_next = S_RD0;
         S_RD0: begin
            w_rd   = 1'b1;
            w_next = S_CAP0;
         end
`ifdef WAVETABLE_INTERP_EN
         S_CAP0: w_next = S_RD1;
         S_RD1: begin
            w_rd   = 1'b1;
            w_next = S_CAP1;
         end
         S_CAP1: w_next = S_CALC;
         S_CALC: w_next = S_IDLE;
`else
         S_CAP0: w_next = S_IDLE;
`endif
         default: w_next = S_IDLE;
      endcase
      // Gate low aborts whatever is in flight.
      if (!enable) w_next = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_phase  <= '0;
         r_addr   <= '0;
         r_sample <= '0;
         r_valid  <= 1'b0;
         r_ovr    <= 1'b0;
`ifdef WAVETABLE_INTERP_EN
         r_s0     <= '0;
         r_s1     <= '0;
         r_frac   <= '0;
`endif
      end else begin
         r_valid <= 1'b0;
         if (!enable) begin
            r_phase  <= '0;
            r_sample <= '0;
         end else begin
            if (sample_tick && r_state != S_IDLE) r_ovr <= 1'b1;
            case (r_state)
               S_IDLE: if (sample_tick) begin
                  r_addr  <= r_phase[PHASE_W-1 -: WT_ADDR_W];
`ifdef WAVETABLE_INTERP_EN
                  r_frac  <= r_phase[PHASE_W-WT_ADDR_W-1 -: FRAC_W];
`endif
                  r_phase <= r_phase + phase_inc;
               end
`ifdef WAVETABLE_INTERP_EN
               S_CAP0: begin
                  r_s0   <= wt_to_signed(ram_rdata);
                  r_addr <= r_addr + 1'b1;
               end
               S_CAP1: r_s1 <= wt_to_signed(ram_rdata);
               S_CALC: begin
                  r_sample <= w_lerp;
                  r_valid  <= 1'b1;
               end
`else
               S_CAP0: begin
                  r_sample <= wt_to_signed(ram_rdata);
                  r_valid  <= 1'b1;
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign ram_addr     = r_addr;
   assign ram_ce       = w_rd;
   assign ram_re       = w_rd;
   assign ram_we       = 1'b0;
   assign ram_wdata    = '0;
   assign sample_out   = r_sample;
   assign sample_valid = r_valid;
   assign busy         = (r_state != S_IDLE);
   assign overrun      = r_ovr;
endmodule

// File: tb/tb_wavetable_reader.sv
// Randomized self-checking bench for wavetable_reader against a phase/table reference model.
// Honours WAVETABLE_INTERP_EN the same way as the design.
module tb_wavetable_reader;
   import synth_pkg::*;

`ifdef WAVETABLE_INTERP_EN
   localparam int LAT = 5;
`else
   localparam int LAT = 2;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        sample_tick = 1'b0;
   logic [23:0] phase_inc = '0;
   logic [8:0]  ram_addr;
   logic        ram_ce, ram_re, ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata = '0;
   logic signed [15:0] sample_out;
   logic        sample_valid, busy, overrun;

   int ntest = 0;
   int nfail = 0;
   int vcount = 0;
   int m_nvalid = 0;
   logic [23:0] m_phase = '0;
   logic [15:0] mem [512];

   wavetable_reader dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .enable       (enable),
      .sample_tick  (sample_tick),
      .phase_inc    (phase_inc),
      .ram_addr     (ram_addr),
      .ram_ce       (ram_ce),
      .ram_re       (ram_re),
      .ram_we       (ram_we),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata),
      .sample_out   (sample_out),
      .sample_valid (sample_valid),
      .busy         (busy),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (ram_ce && ram_re) ram_rdata <= mem[ram_addr];

   always @(negedge clk) if (sample_valid === 1'b1) vcount++;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      ntest++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int tval(input logic [15:0] raw);
      logic signed [15:0] t;
      t = raw ^ 16'h8000;
      return int'(t);
   endfunction

   // Expected sample for a given phase, straight from the table and the lerp formula.
   function automatic int ref_sample(input logic [23:0] ph);
      int a, fr, s0;
      a  = int'(ph[23:15]);
      fr = int'(ph[14:7]);
      s0 = tval(mem[a]);
`ifdef WAVETABLE_INTERP_EN
      begin
         int s1;
         s1 = tval(mem[(a + 1) % 512]);
         return s0 + (((s1 - s0) * fr) >>> 8);
      end
`else
      if (fr < 0) return 0;
      return s0;
`endif
   endfunction

   task automatic tick(input logic [23:0] inc, input string tag);
      int  n, exp;
      bit  got;
      exp = ref_sample(m_phase);
      m_phase = m_phase + inc;
      m_nvalid++;
      @(posedge clk); #1 phase_inc = inc; sample_tick = 1'b1;
      @(posedge clk); #1 sample_tick = 1'b0; phase_inc = 24'($urandom);
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
         @(negedge clk); n++; got = sample_valid;
      end
      chk({tag, "_lat"}, n, LAT + 1);
      chk({tag, "_val"}, {16'd0, sample_out}, {16'd0, 16'(exp)});
      @(negedge clk); chk({tag, "_pw"}, {31'd0, sample_valid}, 0);
   endtask

   task automatic restart();
      @(posedge clk); #1 enable = 1'b0;
      @(posedge clk); #1 chk("dis_out", {16'd0, sample_out}, 0);
      chk("dis_busy", {31'd0, busy}, 0);
      enable = 1'b1;
      m_phase = '0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout tests=%0d", ntest);
      $fatal(1, "timeout");
   end

   initial begin
      int cnt, first;
      for (int i = 0; i < 512; i++) mem[i] = 16'(32'h8000 + 64 * i);

      repeat (3) @(posedge clk);
      #1;
      chk("rst_out", {16'd0, sample_out}, 0);
      chk("rst_vld", {31'd0, sample_valid}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_ovr", {31'd0, overrun}, 0);
      chk("rst_ce", {29'd0, ram_ce, ram_re, ram_we}, 0);
      chk("rst_addr", {23'd0, ram_addr}, 0);
      chk("rst_wd", {16'd0, ram_wdata}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1 enable = 1'b1;

      for (int i = 0; i < 4; i++) tick(24'h008000, "step");

      restart();
      for (int i = 0; i < 4; i++) tick(24'h004000, "half");

      restart();
      tick(24'h000000, "zinc");
      tick(24'h000000, "zinc");

      restart();
      for (int i = 0; i < 513; i++) tick(24'h008000, "wrap");

      restart();
      tick(24'hFFC000, "w511");
      tick(24'h008000, "w511");

      // Overrun: tick held for two cycles, second one lands while busy.
      restart();
      chk("ovr_pre", {31'd0, overrun}, 0);
      first = ref_sample(m_phase);
      m_phase = m_phase + 24'h008000;
      m_nvalid++;
      @(posedge clk); #1 phase_inc = 24'h008000; sample_tick = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1 sample_tick = 1'b0;
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (sample_valid) begin cnt++; chk("ovr_val", {16'd0, sample_out}, {16'd0, 16'(first)}); end
      end
      chk("ovr_cnt", cnt, 1);
      chk("ovr_flag", {31'd0, overrun}, 1);
      tick(24'h008000, "ovr_next");
      chk("ovr_sticky", {31'd0, overrun}, 1);

      // Abort: gate dropped while the read is in flight.
      m_phase = m_phase + 24'h008000;
      @(posedge clk); #1 phase_inc = 24'h008000; sample_tick = 1'b1;
      @(posedge clk); #1 sample_tick = 1'b0; enable = 1'b0;
      cnt = vcount;
      repeat (10) @(negedge clk);
      chk("abort_nv", vcount - cnt, 0);
      chk("abort_out", {16'd0, sample_out}, 0);
      chk("abort_busy", {31'd0, busy}, 0);
      @(posedge clk); #1 enable = 1'b1;
      m_phase = '0;
      tick(24'h008000, "abort_rs");
      tick(24'h008000, "abort_rs");

      // Async reset in CAP0.
      @(posedge clk); #1 phase_inc = 24'h008000; sample_tick = 1'b1;
      @(posedge clk); #1 sample_tick = 1'b0;
      @(posedge clk); #1;
      chk("cap_busy", {31'd0, busy}, 1);
      chk("cap_out", {16'd0, sample_out}, 16'd64);
      chk("cap_ovr", {31'd0, overrun}, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_out", {16'd0, sample_out}, 0);
      chk("arst_ovr", {31'd0, overrun}, 0);
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_ce", {30'd0, ram_ce, ram_re}, 0);
      chk("arst_addr", {23'd0, ram_addr}, 0);
      cnt = vcount;
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("arst_nv", vcount - cnt, 0);
      m_phase = '0;
      tick(24'h008000, "arst_rs");

      // Random table contents and tuning words.
      for (int i = 0; i < 512; i++) mem[i] = 16'($urandom);
      restart();
      for (int i = 0; i < 60; i++) begin
         tick(24'($urandom), "rnd");
         repeat ($urandom_range(0, 3)) @(posedge clk);
      end

      repeat (4) @(negedge clk);
      chk("vld_total", vcount, m_nvalid);
      $display("[TB] %0d tests run, %0d failed", ntest, nfail);
      $finish;
   end
endmodule
